// File: rtl/rv32i_types.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : rv32i_types                                              |
// | Description : Shared RV32 decode types plus the divide reservation     |
// |               station entry, state and result types.                   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package rv32i_types;

    localparam int unsigned c_xlen          = 32;
    // Widths of the struct fields below; div_rs parameters default to these.
    localparam int unsigned c_phys_reg_bits = 6;
    localparam int unsigned c_rob_idx_bits  = 5;

    localparam logic [6:0] c_opcode_op   = 7'b0110011;
    localparam logic [2:0] c_funct3_div  = 3'b100;
    localparam logic [2:0] c_funct3_divu = 3'b101;
    localparam logic [2:0] c_funct3_rem  = 3'b110;
    localparam logic [2:0] c_funct3_remu = 3'b111;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
    } decode_info_t;

    typedef struct packed {
        logic                       valid;
        decode_info_t               info;
        logic [c_phys_reg_bits-1:0] ps1;
        logic                       ps1_rdy;
        logic [c_phys_reg_bits-1:0] ps2;
        logic                       ps2_rdy;
        logic [c_phys_reg_bits-1:0] pd;
        logic [c_rob_idx_bits-1:0]  rob_idx;
    } div_rs_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } div_rs_state_t;

    typedef struct packed {
        logic [c_phys_reg_bits-1:0] pd;
        logic [c_rob_idx_bits-1:0]  rob_idx;
        logic [c_xlen-1:0]          value;
    } div_result_t;

endpackage
`default_nettype wire

// File: rtl/div_rs_age_select.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : div_rs_age_select                                        |
// | Description : Combinational lowest-index-first priority encoder. Index |
// |               0 is the oldest entry, so the grant is the oldest ready. |
// | Ports       : i_req  - per-entry ready request                         |
// |               o_gnt  - one-hot grant                                   |
// |               o_idx  - binary index of the grant                       |
// |               o_any  - at least one request                            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module div_rs_age_select #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [DEPTH-1:0] i_req,
    output logic [DEPTH-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Walk from youngest to oldest so the oldest request wins last.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_gnt    = '0;
                o_gnt[i] = 1'b1;
                o_idx    = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/div_rs.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : div_rs                                                   |
// | Description : Reservation station and completion controller for the   |
// |               RV32M divide/remainder unit. Age-ordered collapsing      |
// |               queue, CDB wakeup, oldest-ready issue to a sequential    |
// |               divider, single result buffer held until CDB grant.      |
// | Ports       : clk, rst_n (async, active-low), flush                    |
// |               disp_*  - dispatch handshake and renamed op fields       |
// |               cdb_*   - wakeup broadcast                               |
// |               prf_*   - same-cycle register file read                  |
// |               fu_*    - divider start/operands/decode and completion   |
// |               res_*   - CDB request, grant and payload                 |
// | Option      : DIV_RS_DIV0_FASTPATH_EN - divide-by-zero results are     |
// |               produced locally without starting the divider.           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module div_rs
    import rv32i_types::*;
#(
    parameter int PHYS_REG_BITS = c_phys_reg_bits,
    parameter int ROB_IDX_BITS  = c_rob_idx_bits,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  decode_info_t             disp_decode_info,
    input  logic [PHYS_REG_BITS-1:0] disp_ps1,
    input  logic [PHYS_REG_BITS-1:0] disp_ps2,
    input  logic [PHYS_REG_BITS-1:0] disp_pd,
    input  logic                     disp_ps1_rdy,
    input  logic                     disp_ps2_rdy,
    input  logic [ROB_IDX_BITS-1:0]  disp_rob_idx,
    input  logic                     cdb_valid,
    input  logic [PHYS_REG_BITS-1:0] cdb_pd,
    output logic [PHYS_REG_BITS-1:0] prf_ps1,
    output logic [PHYS_REG_BITS-1:0] prf_ps2,
    input  logic [31:0]              prf_rs1_v,
    input  logic [31:0]              prf_rs2_v,
    output logic                     fu_start,
    output logic [31:0]              fu_rs1_v,
    output logic [31:0]              fu_rs2_v,
    output decode_info_t             fu_decode_info,
    input  logic [31:0]              fu_rd_v,
    input  logic                     fu_valid,
    output logic                     res_valid,
    input  logic                     res_gnt,
    output logic [PHYS_REG_BITS-1:0] res_pd,
    output logic [ROB_IDX_BITS-1:0]  res_rob_idx,
    output logic [31:0]              res_value
);

    localparam int c_idx_w = $clog2(DEPTH);

    div_rs_entry_t             r_entries [DEPTH];
    // One extra empty slot at the tail feeds the collapsing shift.
    div_rs_entry_t             w_woken   [DEPTH+1];
    div_rs_entry_t             w_next    [DEPTH];
    div_rs_entry_t             w_disp_entry;
    logic [DEPTH-1:0]          w_req;
    logic [DEPTH-1:0]          w_gnt;
    logic [c_idx_w-1:0]        w_sel_idx;
    logic                      w_any;
    logic                      w_issue;
    logic                      w_div0;
    logic                      w_disp_fire;
    div_rs_state_t             r_state;
    div_rs_state_t             w_state_nxt;
    decode_info_t              r_fu_info;
    logic [PHYS_REG_BITS-1:0]  r_fu_pd;
    logic [ROB_IDX_BITS-1:0]   r_fu_rob;
    div_result_t               r_result;
    div_result_t               w_result_nxt;

    // Wakeup of resident entries; select uses the registered ready bits so a
    // broadcast in one cycle permits issue in the next.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_woken[i] = r_entries[i];
            if (cdb_valid && r_entries[i].valid) begin
                if (r_entries[i].ps1 == cdb_pd) w_woken[i].ps1_rdy = 1'b1;
                if (r_entries[i].ps2 == cdb_pd) w_woken[i].ps2_rdy = 1'b1;
            end
            w_req[i] = r_entries[i].valid && r_entries[i].ps1_rdy && r_entries[i].ps2_rdy;
        end
        w_woken[DEPTH] = '0;
    end

    div_rs_age_select #(
        .DEPTH (DEPTH),
        .IDX_W (c_idx_w)
    ) u_age_select (
        .i_req (w_req),
        .o_gnt (w_gnt),
        .o_idx (w_sel_idx),
        .o_any (w_any)
    );

    assign w_issue     = (r_state == IDLE) && w_any && !flush;
    // Entries stay contiguous from index 0, so the tail slot marks full.
    assign disp_ready  = !r_entries[DEPTH-1].valid;
    assign w_disp_fire = disp_valid && disp_ready && !flush;

`ifdef DIV_RS_DIV0_FASTPATH_EN
    assign w_div0 = w_issue && (prf_rs2_v == 32'd0);
`else
    assign w_div0 = 1'b0;
`endif

    always_comb begin
        w_disp_entry         = '0;
        w_disp_entry.valid   = 1'b1;
        w_disp_entry.info    = disp_decode_info;
        w_disp_entry.ps1     = disp_ps1;
        w_disp_entry.ps1_rdy = disp_ps1_rdy || (cdb_valid && cdb_pd == disp_ps1);
        w_disp_entry.ps2     = disp_ps2;
        w_disp_entry.ps2_rdy = disp_ps2_rdy || (cdb_valid && cdb_pd == disp_ps2);
        w_disp_entry.pd      = disp_pd;
        w_disp_entry.rob_idx = disp_rob_idx;
    end

    // Collapse the issued slot (everything at or above it moves down one),
    // then drop the dispatched op into the first free slot.
    always_comb begin
        logic run;
        logic placed;
        run    = 1'b0;
        placed = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            run       = run | (w_issue & w_gnt[i]);
            w_next[i] = run ? w_woken[i+1] : w_woken[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_disp_fire && !placed && !w_next[i].valid) begin
                w_next[i] = w_disp_entry;
                placed    = 1'b1;
            end
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) w_next[i] = '0;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    if (w_div0) begin
                        w_state_nxt          = DONE;
                        w_result_nxt.pd      = r_entries[w_sel_idx].pd;
                        w_result_nxt.rob_idx = r_entries[w_sel_idx].rob_idx;
                        // funct3[1] distinguishes REM/REMU from DIV/DIVU.
                        w_result_nxt.value   = r_entries[w_sel_idx].info.funct3[1] ?
                                               prf_rs1_v : 32'hFFFF_FFFF;
                    end else begin
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                // A flush coinciding with completion leaves nothing to drain.
                if (flush) begin
                    w_state_nxt = fu_valid ? IDLE : DRAIN;
                end else if (fu_valid) begin
                    w_state_nxt          = DONE;
                    w_result_nxt.pd      = r_fu_pd;
                    w_result_nxt.rob_idx = r_fu_rob;
                    w_result_nxt.value   = fu_rd_v;
                end
            end
            DONE: begin
                if (flush || res_gnt) w_state_nxt = IDLE;
            end
            DRAIN: begin
                if (fu_valid) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
            r_state   <= IDLE;
            r_fu_info <= '0;
            r_fu_pd   <= '0;
            r_fu_rob  <= '0;
            r_result  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) r_entries[i] <= w_next[i];
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            if (w_issue) begin
                r_fu_info <= r_entries[w_sel_idx].info;
                r_fu_pd   <= r_entries[w_sel_idx].pd;
                r_fu_rob  <= r_entries[w_sel_idx].rob_idx;
            end
        end
    end

    assign prf_ps1  = w_issue ? r_entries[w_sel_idx].ps1 : '0;
    assign prf_ps2  = w_issue ? r_entries[w_sel_idx].ps2 : '0;
    assign fu_start = w_issue && !w_div0;
    assign fu_rs1_v = fu_start ? prf_rs1_v : '0;
    assign fu_rs2_v = fu_start ? prf_rs2_v : '0;

    // Decode info is live in the issue cycle and held until the divider ends.
    assign fu_decode_info = fu_start ? r_entries[w_sel_idx].info :
                            ((r_state == BUSY) || (r_state == DRAIN)) ? r_fu_info : '0;

    assign res_valid   = (r_state == DONE);
    assign res_pd      = res_valid ? r_result.pd      : '0;
    assign res_rob_idx = res_valid ? r_result.rob_idx : '0;
    assign res_value   = res_valid ? r_result.value   : '0;

endmodule
`default_nettype wire

// File: tb/tb_div_rs.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_div_rs                                                |
// | Description : Directed self-checking bench for div_rs with a behavioral|
// |               sequential divider, a register file and a result queue.  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_div_rs;
    import rv32i_types::*;

    localparam int c_lat = 4;
`ifdef DIV_RS_DIV0_FASTPATH_EN
    localparam bit c_fast = 1'b1;
`else
    localparam bit c_fast = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         disp_valid;
    logic         disp_ready;
    decode_info_t disp_decode_info;
    logic [5:0]   disp_ps1, disp_ps2, disp_pd;
    logic         disp_ps1_rdy, disp_ps2_rdy;
    logic [4:0]   disp_rob_idx;
    logic         cdb_valid;
    logic [5:0]   cdb_pd;
    logic [5:0]   prf_ps1, prf_ps2;
    logic [31:0]  prf_rs1_v, prf_rs2_v;
    logic         fu_start;
    logic [31:0]  fu_rs1_v, fu_rs2_v;
    decode_info_t fu_decode_info;
    logic [31:0]  fu_rd_v;
    logic         fu_valid;
    logic         res_valid;
    logic         res_gnt;
    logic [5:0]   res_pd;
    logic [4:0]   res_rob_idx;
    logic [31:0]  res_value;

    logic [31:0]  prf [64];
    assign prf_rs1_v = prf[prf_ps1];
    assign prf_rs2_v = prf[prf_ps2];

    typedef struct packed {
        logic [5:0]  pd;
        logic [4:0]  rob;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_rs dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .disp_valid       (disp_valid),
        .disp_ready       (disp_ready),
        .disp_decode_info (disp_decode_info),
        .disp_ps1         (disp_ps1),
        .disp_ps2         (disp_ps2),
        .disp_pd          (disp_pd),
        .disp_ps1_rdy     (disp_ps1_rdy),
        .disp_ps2_rdy     (disp_ps2_rdy),
        .disp_rob_idx     (disp_rob_idx),
        .cdb_valid        (cdb_valid),
        .cdb_pd           (cdb_pd),
        .prf_ps1          (prf_ps1),
        .prf_ps2          (prf_ps2),
        .prf_rs1_v        (prf_rs1_v),
        .prf_rs2_v        (prf_rs2_v),
        .fu_start         (fu_start),
        .fu_rs1_v         (fu_rs1_v),
        .fu_rs2_v         (fu_rs2_v),
        .fu_decode_info   (fu_decode_info),
        .fu_rd_v          (fu_rd_v),
        .fu_valid         (fu_valid),
        .res_valid        (res_valid),
        .res_gnt          (res_gnt),
        .res_pd           (res_pd),
        .res_rob_idx      (res_rob_idx),
        .res_value        (res_value)
    );

    // RV32M reference semantics, used by the behavioral divider.
    function automatic logic [31:0] div_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            c_funct3_div:  r = (b == 0) ? 32'hFFFF_FFFF :
                               (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a :
                               32'($signed(a) / $signed(b));
            c_funct3_rem:  r = (b == 0) ? a :
                               (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 :
                               32'($signed(a) % $signed(b));
            c_funct3_divu: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:       r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Behavioral divider: latches operands on fu_start, pulses fu_valid
    // c_lat cycles later.
    initial begin
        int          cnt;
        logic [31:0] res;
        cnt      = 0;
        res      = '0;
        fu_valid = 1'b0;
        fu_rd_v  = '0;
        forever begin
            @(negedge clk);
            if (fu_start === 1'b1) begin
                res = div_model(fu_decode_info.funct3, fu_rs1_v, fu_rs2_v);
                cnt = c_lat;
            end
            @(posedge clk);
            #1;
            fu_valid = 1'b0;
            fu_rd_v  = '0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    fu_valid = 1'b1;
                    fu_rd_v  = res;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
        res_gnt    = 1'b0;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic dispatch(input logic [2:0] f3, input logic [5:0] s1, input logic r1,
                            input logic [5:0] s2, input logic r2, input logic [5:0] d,
                            input logic [4:0] rob);
        disp_valid              = 1'b1;
        disp_decode_info.opcode = c_opcode_op;
        disp_decode_info.funct3 = f3;
        disp_ps1                = s1;
        disp_ps1_rdy            = r1;
        disp_ps2                = s2;
        disp_ps2_rdy            = r2;
        disp_pd                 = d;
        disp_rob_idx            = rob;
    endtask

    task automatic expect_res(input logic [5:0] d, input logic [4:0] rob, input logic [31:0] v);
        exp_t e;
        e.pd  = d;
        e.rob = rob;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic broadcast(input logic [5:0] tag);
        cdb_valid = 1'b1;
        cdb_pd    = tag;
    endtask

    // Called at mid-cycle. Waits for res_valid, compares against the queue
    // head, checks the payload holds for 'hold' cycles, then grants.
    task automatic get_result(input int exp_lat, input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (res_valid !== 1'b1 && n < 40) begin
            step();
            mid();
            n++;
        end
        check("res_seen", 32'(res_valid), 32'd1);
        check("res_latency", 32'(n), 32'(exp_lat));
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        check("res_pd", 32'(res_pd), 32'(e.pd));
        check("res_rob_idx", 32'(res_rob_idx), 32'(e.rob));
        check("res_value", res_value, e.val);
        for (int h = 0; h < hold; h++) begin
            step();
            mid();
            check("res_hold_valid", 32'(res_valid), 32'd1);
            check("res_hold_value", res_value, e.val);
            check("res_hold_no_start", 32'(fu_start), 32'd0);
        end
        res_gnt = 1'b1;
        step();
        mid();
        check("res_drop_after_gnt", 32'(res_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) prf[i] = 32'(i);
        prf[3]  = 32'd100;         prf[4]  = 32'd7;
        prf[5]  = 32'hFFFF_FFF9;   prf[6]  = 32'd3;
        prf[7]  = 32'd50;          prf[8]  = 32'd23;   prf[20] = 32'd5;
        prf[24] = 32'd40;          prf[25] = 32'd8;
        prf[26] = 32'h8000_0000;   prf[27] = 32'hFFFF_FFFF;
        prf[28] = 32'd5;           prf[29] = 32'd0;
        rst_n = 1'b0;
        flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0; cdb_pd = '0; res_gnt = 1'b0;
        disp_decode_info = '0; disp_ps1 = '0; disp_ps2 = '0; disp_pd = '0;
        disp_ps1_rdy = 1'b0; disp_ps2_rdy = 1'b0; disp_rob_idx = '0;

        // Reset values
        step(); step(); mid();
        check("rst_disp_ready", 32'(disp_ready), 32'd1);
        check("rst_fu_start", 32'(fu_start), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_value", res_value, 32'd0);
        check("rst_res_pd", 32'(res_pd), 32'd0);
        check("rst_prf_ps1", 32'(prf_ps1), 32'd0);
        check("rst_fu_rs1_v", fu_rs1_v, 32'd0);
        check("rst_fu_decode", 32'(fu_decode_info), 32'd0);
        step();
        rst_n = 1'b1;

        // DIV 100/7, both sources ready
        step(); dispatch(c_funct3_div, 6'd3, 1'b1, 6'd4, 1'b1, 6'd10, 5'd1);
        expect_res(6'd10, 5'd1, 32'd14);
        mid(); check("t1_no_same_cycle_issue", 32'(fu_start), 32'd0);
        step(); mid();
        check("t1_start", 32'(fu_start), 32'd1);
        check("t1_prf_ps1", 32'(prf_ps1), 32'd3);
        check("t1_prf_ps2", 32'(prf_ps2), 32'd4);
        check("t1_fu_rs1_v", fu_rs1_v, 32'd100);
        check("t1_fu_rs2_v", fu_rs2_v, 32'd7);
        check("t1_fu_funct3", 32'(fu_decode_info.funct3), 32'(c_funct3_div));
        get_result(c_lat + 1, 2);

        // REM with ps2 woken by the CDB
        step(); dispatch(c_funct3_rem, 6'd5, 1'b1, 6'd6, 1'b0, 6'd11, 5'd2);
        expect_res(6'd11, 5'd2, 32'hFFFF_FFFF);
        mid();
        step(); mid(); check("t2_wait_operand", 32'(fu_start), 32'd0);
        step(); broadcast(6'd6); mid();
        check("t2_no_issue_bcast_cycle", 32'(fu_start), 32'd0);
        step(); mid();
        check("t2_issue_after_wakeup", 32'(fu_start), 32'd1);
        check("t2_prf_ps2", 32'(prf_ps2), 32'd6);
        get_result(c_lat + 1, 1);

        // Fill the station; oldest and youngest share the pending tag
        step(); dispatch(c_funct3_divu, 6'd7, 1'b1, 6'd20, 1'b0, 6'd12, 5'd3);
        expect_res(6'd12, 5'd3, 32'd10);
        mid(); check("t3_ready_empty", 32'(disp_ready), 32'd1);
        step(); dispatch(c_funct3_div, 6'd9, 1'b1, 6'd21, 1'b0, 6'd13, 5'd4); mid();
        step(); dispatch(c_funct3_div, 6'd9, 1'b1, 6'd22, 1'b0, 6'd14, 5'd5); mid();
        step(); dispatch(c_funct3_remu, 6'd8, 1'b1, 6'd20, 1'b0, 6'd15, 5'd6);
        expect_res(6'd15, 5'd6, 32'd3);
        mid(); check("t3_ready_three", 32'(disp_ready), 32'd1);
        step(); mid(); check("t3_full", 32'(disp_ready), 32'd0);
        step(); broadcast(6'd20); mid();
        check("t3_no_issue_bcast_cycle", 32'(fu_start), 32'd0);
        step(); mid();
        check("t3_oldest_issue", 32'(fu_start), 32'd1);
        check("t3_oldest_tag", 32'(prf_ps1), 32'd7);
        check("t3_full_during_issue", 32'(disp_ready), 32'd0);
        get_result(c_lat + 1, 2);
        check("t3_second_after_gnt", 32'(fu_start), 32'd1);
        check("t3_youngest_tag", 32'(prf_ps1), 32'd8);
        get_result(c_lat + 1, 1);

        // Flush while the divider is busy
        step(); broadcast(6'd21); mid();
        step(); mid();
        check("t4_issue", 32'(fu_start), 32'd1);
        check("t4_issue_tag", 32'(prf_ps2), 32'd21);
        step(); mid();
        step(); flush = 1'b1;
        dispatch(c_funct3_divu, 6'd24, 1'b1, 6'd25, 1'b1, 6'd19, 5'd10);
        mid(); check("t4_no_issue_in_flush", 32'(fu_start), 32'd0);
        step(); dispatch(c_funct3_divu, 6'd24, 1'b1, 6'd25, 1'b1, 6'd16, 5'd7);
        expect_res(6'd16, 5'd7, 32'd5);
        mid();
        check("t4_drain_no_start", 32'(fu_start), 32'd0);
        check("t4_drain_no_result", 32'(res_valid), 32'd0);
        step(); mid();
        check("t4_drain_wait", 32'(fu_start), 32'd0);
        step(); mid();
        check("t4_discarded_result", 32'(res_valid), 32'd0);
        check("t4_issue_after_drain", 32'(fu_start), 32'd1);
        get_result(c_lat + 1, 1);
        check("t4_flushed_dispatch_dropped", 32'(fu_start), 32'd0);
        step(); broadcast(6'd22); mid();
        for (int i = 0; i < 3; i++) begin
            step(); mid();
            check("t4_entries_cleared", 32'(fu_start), 32'd0);
        end

        // Signed overflow case; second dispatch coincides with first issue
        step(); dispatch(c_funct3_div, 6'd26, 1'b1, 6'd27, 1'b1, 6'd17, 5'd8);
        expect_res(6'd17, 5'd8, 32'h8000_0000);
        mid();
        step(); dispatch(c_funct3_rem, 6'd26, 1'b1, 6'd27, 1'b1, 6'd18, 5'd9);
        expect_res(6'd18, 5'd9, 32'd0);
        mid(); check("t5_div_issue", 32'(fu_start), 32'd1);
        get_result(c_lat + 1, 1);
        check("t5_rem_issue", 32'(fu_start), 32'd1);
        get_result(c_lat + 1, 1);

        // Unsigned divide by zero
        step(); dispatch(c_funct3_divu, 6'd28, 1'b1, 6'd29, 1'b1, 6'd20, 5'd11);
        expect_res(6'd20, 5'd11, 32'hFFFF_FFFF);
        mid();
        step(); mid();
        check("t6_divu0_start", 32'(fu_start), c_fast ? 32'd0 : 32'd1);
        get_result(c_fast ? 1 : c_lat + 1, 1);
        step(); dispatch(c_funct3_remu, 6'd28, 1'b1, 6'd29, 1'b1, 6'd21, 5'd12);
        expect_res(6'd21, 5'd12, 32'd5);
        mid();
        step(); mid();
        check("t6_remu0_start", 32'(fu_start), c_fast ? 32'd0 : 32'd1);
        get_result(c_fast ? 1 : c_lat + 1, 1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_rs.md
# div_rs

Reservation station and completion controller for the RV32M divide/remainder functional unit. It accepts renamed DIV/DIVU/REM/REMU micro-ops from dispatch and wakes sources from the CDB. It issues the oldest ready op to the sequential divider, holds that op's decode info stable until the divider completes, and buffers the result until the CDB arbiter grants it. Position: between dispatch/rename and the CDB, wrapping the divider unit.

## Interface
- PHYS_REG_BITS, 6, physical register tag width
- ROB_IDX_BITS, 5, ROB index width
- DEPTH, 4, station entries (≥2)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  squash all entries and any in-flight op
- disp_valid / disp_ready  in/out  1  dispatch handshake; disp_ready = not full
- disp_decode_info  in  decode_info_t  opcode/funct3 of dispatched op
- disp_ps1, disp_ps2, disp_pd  in  PHYS_REG_BITS  source and destination tags
- disp_ps1_rdy, disp_ps2_rdy  in  1  source already available
- disp_rob_idx  in  ROB_IDX_BITS  ROB slot
- cdb_valid  in  1, cdb_pd  in  PHYS_REG_BITS  wakeup broadcast
- prf_ps1, prf_ps2  out  PHYS_REG_BITS  combinational register-file read addresses
- prf_rs1_v, prf_rs2_v  in  32  read data, same cycle
- fu_start  out  1  one-cycle start pulse to divider
- fu_rs1_v, fu_rs2_v  out  32  operands, equal to prf_rs*_v
- fu_decode_info  out  decode_info_t  in-flight op, stable from issue to fu_valid
- fu_rd_v  in  32, fu_valid  in  1  divider result and one-cycle completion pulse
- res_valid  out  1, res_gnt  in  1  CDB request/grant
- res_pd  out  PHYS_REG_BITS, res_rob_idx  out  ROB_IDX_BITS, res_value  out  32

## Operation
- Entries are kept in age order by a collapsing shift. Index 0 is the oldest. Entry = {valid, decode_info, ps1, ps1_rdy, ps2, ps2_rdy, pd, rob_idx}.
- Dispatch writes at the first free slot after the same-cycle issue shift.
- Wakeup: each valid entry sets ps*_rdy when cdb_valid and cdb_pd match. A dispatching op whose ps matches the same-cycle cdb_pd is written ready.
- Select: lowest index with both sources ready. Issue is permitted only in IDLE. On issue, prf_ps* = the entry's tags, fu_start=1, and the entry is removed.
- FSM:
  - IDLE→BUSY on issue.
  - BUSY→DONE on fu_valid, capturing fu_rd_v, pd and rob_idx into the result buffer.
  - BUSY→DRAIN if flush occurs while BUSY. DRAIN→IDLE on fu_valid; the result is discarded.
  - DONE→IDLE on res_gnt.
- Flush: clears all entries. Clears a DONE result (state to IDLE). A BUSY op goes to DRAIN, because the divider cannot be aborted.
- Flush has priority over a same-cycle dispatch (dispatch dropped), issue (suppressed), and res_gnt.
- fu_start is suppressed in DRAIN.
- Outputs are 0 unless stated otherwise.

## Timing
- Reset: all entries invalid, state IDLE, disp_ready=1, fu_start=0, res_valid=0, all data outputs 0.
- A dispatch in cycle T is selectable at T+1. A wakeup in cycle T allows issue at T+1.
- Issue at T, fu_valid at T+k (k set by divider, ≥4). res_valid rises at T+k+1 and holds with stable payload until res_gnt. The next issue is no earlier than the cycle after res_gnt.
- Full: disp_ready=0 when DEPTH entries are valid, even if an issue occurs the same cycle (no combinational ready path).
- Dispatch and issue in the same cycle: shift, then write. The count is unchanged.
- fu_valid while IDLE/DONE is ignored.

## Configuration
- DIV_RS_DIV0_FASTPATH_EN defined: an issuing op with prf_rs2_v==0 does not assert fu_start. The state goes IDLE→DONE directly.
  - DIV/DIVU result: 0xFFFFFFFF.
  - REM/REMU result: prf_rs1_v.
  - res_valid rises at T+1.
- Undefined: divide-by-zero goes through the divider like any other op.

## Structure
- Add to rv32i_types: div_rs_entry_t, div_rs_state_t (IDLE, BUSY, DONE, DRAIN), div_result_t {pd, rob_idx, value}.
- One sub-module: div_rs_age_select. It is a combinational lowest-index-ready priority encoder producing a grant one-hot plus an index.

## Test plan
- Dispatch DIV ps1=3 (rs1_v 100), ps2=4 (rs2_v 7), both ready → fu_start one cycle later; res_value=14 after fu_valid; held until res_gnt.
- Dispatch REM with ps2 not ready, then CDB cdb_pd=ps2 → issue the cycle after the broadcast; result -7 rem 3 = 0xFFFFFFFF.
- Fill DEPTH entries → disp_ready=0. Ready both the oldest and the youngest → the oldest issues first. Second issue happens only after res_gnt.
- Flush 2 cycles after issue → entries cleared, no res_valid; the next dispatch issues only after the discarded fu_valid.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
- DIVU 5/0 and REMU 5/0 → 0xFFFFFFFF and 5. With DIV_RS_DIV0_FASTPATH_EN there is no fu_start and res_valid comes one cycle after select.
